// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA slot scheduler: default sizing, slot-index
// width and the scheduler state encoding.
package cgra_pkg;

  localparam int unsigned N_SLOTS    = 2;
  localparam int unsigned N_COL      = 4;
  localparam int unsigned SLOT_IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StLaunch,
    StAck
  } sched_state_e;

endpackage

// File: rtl/cgra_col_alloc.sv
// Combinational column allocator: finds the lowest-indexed contiguous window of
// (ncol_i + 1) free columns in busy_i. Windows never wrap past column N_COL-1.
module cgra_col_alloc #(
  parameter int unsigned N_COL = 4
) (
  input  logic [N_COL-1:0] busy_i,
  input  logic [1:0]       ncol_i,
  output logic [N_COL-1:0] mask_o,
  output logic             fit_o
);

  int                 width;
  logic [N_COL-1:0]   win;

  // Scan start positions from the top down so the lowest fitting window wins.
  always_comb begin
    width  = 32'(ncol_i) + 1;
    mask_o = '0;
    fit_o  = 1'b0;
    win    = '0;
    for (int s = int'(N_COL) - 1; s >= 0; s--) begin
      for (int c = 0; c < int'(N_COL); c++) begin
        win[c] = (c >= s) && (c < s + width);
      end
      // A window running off the top column is not a window at all.
      if ((s + width <= int'(N_COL)) && ((busy_i & win) == '0)) begin
        fit_o  = 1'b1;
        mask_o = win;
      end
    end
  end

endmodule

// File: rtl/cgra_slot_scheduler.sv
// CGRA slot scheduler: picks a pending kernel request, allocates a contiguous
// column window, hands it to the context loader and acknowledges the slot.
// Optional feature macro: CGRA_SCHED_RR_EN selects round-robin slot priority;
// when undefined, the lowest requesting slot index that fits wins.
module cgra_slot_scheduler
  import cgra_pkg::*;
#(
  parameter int unsigned N_SLOTS  = cgra_pkg::N_SLOTS,
  parameter int unsigned N_COL    = cgra_pkg::N_COL,
  parameter int unsigned KER_ID_W = 4,
  localparam int unsigned IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [N_SLOTS-1:0][KER_ID_W-1:0]   slot_ker_id_i,
  input  logic [N_SLOTS-1:0][1:0]            slot_ncol_i,
  input  logic [N_COL-1:0]                   col_status_i,
  output logic                               launch_valid_o,
  input  logic                               launch_ready_i,
  output logic [KER_ID_W-1:0]                launch_ker_id_o,
  output logic [N_COL-1:0]                   launch_col_mask_o,
  output logic [N_COL-1:0]                   acc_req_o,
  output logic                               acc_ack_o,
  output logic [IDX_W-1:0]                   c_id_req_clear_o
);

  sched_state_e state_q, state_d;

  logic [N_SLOTS-1:0]            slot_req;
  logic [N_SLOTS-1:0]            slot_fit;
  logic [N_SLOTS-1:0]            slot_cand;
  logic [N_SLOTS-1:0][N_COL-1:0] slot_mask;
  logic                          any_req;

  logic                          sel_found;
  logic [IDX_W-1:0]              sel_idx;

  logic [KER_ID_W-1:0]           id_q;
  logic [N_COL-1:0]              mask_q;
  logic [IDX_W-1:0]              slot_q;

  // One allocator per slot so a slot that does not fit cannot hide one that does.
  for (genvar g = 0; g < int'(N_SLOTS); g++) begin : g_slot
    assign slot_req[g] = |slot_ker_id_i[g];

    cgra_col_alloc #(
      .N_COL (N_COL)
    ) u_col_alloc (
      .busy_i (col_status_i),
      .ncol_i (slot_ncol_i[g]),
      .mask_o (slot_mask[g]),
      .fit_o  (slot_fit[g])
    );
  end

  assign slot_cand = slot_req & slot_fit;
  assign any_req   = |slot_req;

`ifdef CGRA_SCHED_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;
  int unsigned      cand_i;

  // Round-robin pick: first fitting request at or after the pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_i    = 0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      cand_i = (32'(rr_ptr_q) + k) % N_SLOTS;
      if (!sel_found && slot_cand[IDX_W'(cand_i)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand_i);
      end
    end
  end

  // Pointer moves to the slot after the one just acknowledged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (state_q == StAck) begin
      rr_ptr_q <= (slot_q == IDX_W'(N_SLOTS - 1)) ? '0 : slot_q + IDX_W'(1);
    end
  end
`else
  // Fixed priority pick: lowest fitting slot index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      if (!sel_found && slot_cand[IDX_W'(k)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) state_d = StArb;
      end
      StArb: begin
        if (!any_req) begin
          state_d = StIdle;
        end else if (sel_found) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        // Launch completes even if the slot ID was dropped meanwhile.
        if (launch_ready_i) state_d = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture the winning slot, its ID and granted window at the end of arbitration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q   <= '0;
      mask_q <= '0;
      slot_q <= '0;
    end else if ((state_q == StArb) && sel_found) begin
      id_q   <= slot_ker_id_i[sel_idx];
      mask_q <= slot_mask[sel_idx];
      slot_q <= sel_idx;
    end
  end

  // Outputs decoded from state; everything is zero outside its own phase.
  always_comb begin
    launch_valid_o    = 1'b0;
    launch_ker_id_o   = '0;
    launch_col_mask_o = '0;
    acc_ack_o         = 1'b0;
    acc_req_o         = '0;
    c_id_req_clear_o  = '0;
    unique case (state_q)
      StLaunch: begin
        launch_valid_o    = 1'b1;
        launch_ker_id_o   = id_q;
        launch_col_mask_o = mask_q;
      end
      StAck: begin
        acc_ack_o        = 1'b1;
        acc_req_o        = mask_q;
        c_id_req_clear_o = slot_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cgra_slot_scheduler.sv
// Self-checking bench for cgra_slot_scheduler: directed scenarios followed by a
// randomized run compared against a transaction-level reference model.
module tb_cgra_slot_scheduler;

  localparam int NS = 2;
  localparam int NC = 4;
  localparam int KW = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NS-1:0][KW-1:0]   slot_ker_id = '0;
  logic [NS-1:0][1:0]      slot_ncol = '0;
  logic [NC-1:0]           col_status = '0;
  logic                    launch_ready = 1'b0;
  logic                    launch_valid;
  logic [KW-1:0]           launch_ker_id;
  logic [NC-1:0]           launch_col_mask;
  logic [NC-1:0]           acc_req;
  logic                    acc_ack;
  logic [0:0]              clear_idx;

  int n_checks = 0;
  int n_errors = 0;
  int mptr = 0;

  cgra_slot_scheduler #(
    .N_SLOTS  (NS),
    .N_COL    (NC),
    .KER_ID_W (KW)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .slot_ker_id_i     (slot_ker_id),
    .slot_ncol_i       (slot_ncol),
    .col_status_i      (col_status),
    .launch_valid_o    (launch_valid),
    .launch_ready_i    (launch_ready),
    .launch_ker_id_o   (launch_ker_id),
    .launch_col_mask_o (launch_col_mask),
    .acc_req_o         (acc_req),
    .acc_ack_o         (acc_ack),
    .c_id_req_clear_o  (clear_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lowest contiguous window of ncol+1 free columns, or -1 when none exists.
  function automatic int col_fit(input int busy, input int ncol);
    int w;
    int m;
    w = ncol + 1;
    for (int s = 0; s + w <= NC; s++) begin
      m = ((1 << w) - 1) << s;
      if ((m & busy) == 0) return m;
    end
    return -1;
  endfunction

  task automatic model_pick(input logic [NS-1:0][KW-1:0] ids, input logic [NS-1:0][1:0] nc,
                            input logic [NC-1:0] busy, output int slot, output int mask);
    int start;
    int i;
    int m;
`ifdef CGRA_SCHED_RR_EN
    start = mptr;
`else
    start = 0;
`endif
    slot = -1;
    mask = 0;
    for (int k = 0; k < NS; k++) begin
      i = (start + k) % NS;
      if (slot < 0 && ids[i] != '0) begin
        m = col_fit(int'(busy), int'(nc[i]));
        if (m >= 0) begin
          slot = i;
          mask = m;
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    slot_ker_id = '0;
    slot_ncol = '0;
    col_status = '0;
    launch_ready = 1'b0;
    repeat (2) step();
    check_eq("rst_valid", 32'(launch_valid), 0);
    check_eq("rst_ack", 32'(acc_ack), 0);
    check_eq("rst_req", 32'(acc_req), 0);
    rst_n = 1'b1;
    step();
    mptr = 0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (launch_valid) break;
      step();
    end
    check_eq(tag, 32'(launch_valid), 1);
  endtask

  task automatic wait_ack(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (acc_ack) break;
      step();
    end
    check_eq(tag, 32'(acc_ack), 1);
  endtask

  logic [NS-1:0][KW-1:0] p_ids;
  logic [NS-1:0][1:0]    p_nc;
  logic [NC-1:0]         p_col;
  logic                  p_valid;
  logic                  p_ready;
  logic                  exp_ack;
  int                    e_id;
  int                    e_mask;
  int                    e_slot;
  int                    ms;
  int                    mm;

  initial begin
    // Single request, all columns free: valid two cycles later, one ack.
    apply_reset();
    check_eq("rst_id", 32'(launch_ker_id), 0);
    check_eq("rst_mask", 32'(launch_col_mask), 0);
    check_eq("rst_clear", 32'(clear_idx), 0);
    launch_ready = 1'b1;
    slot_ker_id[0] = 4'd3;
    slot_ncol[0] = 2'd1;
    step();
    check_eq("t1_arb_valid", 32'(launch_valid), 0);
    step();
    check_eq("t1_valid", 32'(launch_valid), 1);
    check_eq("t1_id", 32'(launch_ker_id), 3);
    check_eq("t1_mask", 32'(launch_col_mask), 32'h3);
    step();
    check_eq("t1_ack", 32'(acc_ack), 1);
    check_eq("t1_req", 32'(acc_req), 32'h3);
    check_eq("t1_clear", 32'(clear_idx), 0);
    check_eq("t1_valid_off", 32'(launch_valid), 0);
    slot_ker_id[0] = '0;
    step();
    check_eq("t1_ack_pulse", 32'(acc_ack), 0);
    check_eq("t1_req_zero", 32'(acc_req), 0);
    step();

    // No fit in 0101 until column 2 frees up: window 0110.
    slot_ker_id[0] = 4'd5;
    slot_ncol[0] = 2'd1;
    col_status = 4'b0101;
    repeat (6) begin
      step();
      check_eq("t2_nofit", 32'(launch_valid), 0);
    end
    col_status = 4'b0001;
    step();
    check_eq("t2_valid", 32'(launch_valid), 1);
    check_eq("t2_mask", 32'(launch_col_mask), 32'h6);
    step();
    check_eq("t2_ack", 32'(acc_ack), 1);
    slot_ker_id[0] = '0;
    step();
    step();

    // A non-fitting slot 0 must not block slot 1.
    slot_ker_id[0] = 4'd7;
    slot_ncol[0] = 2'd3;
    slot_ker_id[1] = 4'd9;
    slot_ncol[1] = 2'd0;
    col_status = 4'b0001;
    step();
    step();
    check_eq("t3_valid", 32'(launch_valid), 1);
    check_eq("t3_id", 32'(launch_ker_id), 9);
    check_eq("t3_mask", 32'(launch_col_mask), 32'h2);
    step();
    check_eq("t3_ack", 32'(acc_ack), 1);
    check_eq("t3_clear", 32'(clear_idx), 1);
    slot_ker_id[1] = '0;
    repeat (5) begin
      step();
      check_eq("t3_pending", 32'(launch_valid), 0);
    end
    col_status = 4'b0000;
    step();
    check_eq("t3_late_valid", 32'(launch_valid), 1);
    check_eq("t3_late_id", 32'(launch_ker_id), 7);
    check_eq("t3_late_mask", 32'(launch_col_mask), 32'hf);
    step();
    check_eq("t3_late_clear", 32'(clear_idx), 0);
    slot_ker_id[0] = '0;
    step();
    step();

    // Both slots requesting continuously.
    apply_reset();
    launch_ready = 1'b1;
    slot_ker_id[0] = 4'd1;
    slot_ker_id[1] = 4'd2;
    for (int g = 0; g < 4; g++) begin
      wait_ack("t4_ack", 12);
`ifdef CGRA_SCHED_RR_EN
      check_eq("t4_grant", 32'(clear_idx), 32'(g % 2));
`else
      check_eq("t4_grant", 32'(clear_idx), 0);
`endif
      step();
    end
    slot_ker_id = '0;
    step();
    step();

    // Back-pressure: launch held stable while ready is low.
    launch_ready = 1'b0;
    slot_ker_id[0] = 4'd4;
    slot_ncol[0] = 2'd2;
    wait_valid("t5_valid", 10);
    repeat (5) begin
      step();
      check_eq("t5_hold_valid", 32'(launch_valid), 1);
      check_eq("t5_hold_id", 32'(launch_ker_id), 4);
      check_eq("t5_hold_mask", 32'(launch_col_mask), 32'h7);
      check_eq("t5_no_ack", 32'(acc_ack), 0);
    end
    launch_ready = 1'b1;
    step();
    check_eq("t5_ack", 32'(acc_ack), 1);
    check_eq("t5_req", 32'(acc_req), 32'h7);
    slot_ker_id[0] = '0;
    step();
    step();

    // Reset during launch aborts it immediately.
    launch_ready = 1'b0;
    slot_ker_id[0] = 4'd6;
    slot_ncol[0] = 2'd0;
    wait_valid("t6_valid", 10);
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid", 32'(launch_valid), 0);
    check_eq("t6_id", 32'(launch_ker_id), 0);
    check_eq("t6_mask", 32'(launch_col_mask), 0);
    check_eq("t6_ack", 32'(acc_ack), 0);
    check_eq("t6_req", 32'(acc_req), 0);
    check_eq("t6_clear", 32'(clear_idx), 0);
    slot_ker_id = '0;
    launch_ready = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (4) begin
      step();
      check_eq("t6_post_ack", 32'(acc_ack), 0);
      check_eq("t6_post_valid", 32'(launch_valid), 0);
    end

    // Randomized run against the reference model.
    apply_reset();
    p_ids = '0;
    p_nc = '0;
    p_col = '0;
    p_valid = 1'b0;
    p_ready = 1'b0;
    e_id = 0;
    e_mask = 0;
    e_slot = 0;
    for (int n = 0; n < 1500; n++) begin
      step();
      exp_ack = p_valid && p_ready;
      check_eq("rnd_ack", 32'(acc_ack), 32'(exp_ack));
      if (exp_ack) begin
        check_eq("rnd_ack_req", 32'(acc_req), 32'(e_mask));
        check_eq("rnd_ack_clear", 32'(clear_idx), 32'(e_slot));
        check_eq("rnd_ack_valid", 32'(launch_valid), 0);
        mptr = (e_slot + 1) % NS;
        if ($urandom_range(1, 0) == 1) slot_ker_id[e_slot] = '0;
      end else begin
        check_eq("rnd_req_zero", 32'(acc_req), 0);
      end
      if (launch_valid && !p_valid) begin
        model_pick(p_ids, p_nc, p_col, ms, mm);
        e_slot = (ms < 0) ? 0 : ms;
        e_id = (ms < 0) ? 0 : int'(p_ids[e_slot]);
        e_mask = mm;
        check_eq("rnd_launch_id", 32'(launch_ker_id), 32'(e_id));
        check_eq("rnd_launch_mask", 32'(launch_col_mask), 32'(e_mask));
      end else if (launch_valid) begin
        check_eq("rnd_hold_id", 32'(launch_ker_id), 32'(e_id));
        check_eq("rnd_hold_mask", 32'(launch_col_mask), 32'(e_mask));
      end
      if ($urandom_range(3, 0) == 0) col_status = NC'($urandom_range(15, 0));
      for (int s = 0; s < NS; s++) begin
        if (slot_ker_id[s] == '0) begin
          if ($urandom_range(2, 0) == 0) begin
            slot_ker_id[s] = KW'($urandom_range(15, 1));
            slot_ncol[s] = 2'($urandom_range(3, 0));
          end
        end else if ($urandom_range(19, 0) == 0) begin
          slot_ker_id[s] = '0;
        end
      end
      launch_ready = ($urandom_range(1, 0) == 1);
      p_ids = slot_ker_id;
      p_nc = slot_ncol;
      p_col = col_status;
      p_valid = launch_valid;
      p_ready = launch_ready;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cgra_slot_scheduler.md
CGRA_SLOT_SCHEDULER -- requirements
Module: cgra_slot_scheduler

Interface
REQ-001 SHALL have parameter N_SLOTS, default 2: number of kernel request slots.
REQ-002 SHALL have parameter N_COL, default 4: number of CGRA columns.
REQ-003 SHALL have parameter KER_ID_W, default 4: kernel-ID width; ID 0 means "no request".
REQ-004 SHALL have port clk_i  input  1: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_ni  input  1: asynchronous active-low reset.
REQ-006 SHALL have port slot_ker_id_i  input  N_SLOTS x KER_ID_W: pending kernel ID per slot; nonzero means a request.
REQ-007 SHALL have port slot_ncol_i  input  N_SLOTS x 2: columns required minus one (0..3 gives 1..4 columns).
REQ-008 SHALL have port col_status_i  input  N_COL: busy column mask, 1 = used.
REQ-009 SHALL have port launch_valid_o  output  1: launch request to the context loader.
REQ-010 SHALL have port launch_ready_i  input  1: context loader accepts the launch.
REQ-011 SHALL have port launch_ker_id_o  output  KER_ID_W: kernel ID of the launch.
REQ-012 SHALL have port launch_col_mask_o  output  N_COL: columns granted to the launch.
REQ-013 SHALL have port acc_req_o  output  N_COL: column mask of the accepted launch.
REQ-014 SHALL have port acc_ack_o  output  1: one-cycle pulse when a launch is accepted.
REQ-015 SHALL have port c_id_req_clear_o  output  log2(N_SLOTS): index of the slot whose ID is cleared.

Function
REQ-016 SHALL implement the FSM states IDLE, ARB, LAUNCH and ACK.
REQ-017 In IDLE, SHALL move to ARB on the cycle after any slot_ker_id_i is nonzero.
REQ-018 In ARB, SHALL select one requesting slot per the priority rule and register its ID and ncol.
REQ-019 In ARB, SHALL compute the lowest-indexed contiguous window of ncol+1 free columns in col_status_i.
REQ-020 A window SHALL not wrap from column N_COL-1 to column 0.
REQ-021 If a window fits, SHALL register the mask and go to LAUNCH; otherwise SHALL stay in ARB and retry every cycle.
REQ-022 A slot whose request does not fit SHALL not block another slot whose request fits.
REQ-023 If no slot is requesting in ARB, SHALL return to IDLE.
REQ-024 In LAUNCH, SHALL assert launch_valid_o with the registered ID and mask held stable until launch_ready_i.
REQ-025 SHALL complete the launch on the cycle where launch_valid_o and launch_ready_i are both high, then go to ACK.
REQ-026 In ACK, SHALL pulse acc_ack_o high for exactly one cycle.
REQ-027 In ACK, SHALL drive acc_req_o to the granted mask and c_id_req_clear_o to the granted slot.
REQ-028 Outside ACK, acc_req_o SHALL be zero.
REQ-029 After ACK, SHALL return to IDLE.
REQ-030 Latency from a request to launch_valid_o SHALL be 2 cycles when columns are free.
REQ-031 If the granted slot's ID drops to 0 while in LAUNCH, SHALL still complete the launch; the request is not retracted.
REQ-032 An ncol+1 value greater than N_COL SHALL never fit; that slot SHALL be skipped.

Reset
REQ-033 While rst_ni is low, SHALL force state IDLE and launch_valid_o=0.
REQ-034 While rst_ni is low, SHALL force acc_ack_o=0, acc_req_o=0, launch_col_mask_o=0, launch_ker_id_o=0 and c_id_req_clear_o=0.
REQ-035 While rst_ni is low, SHALL set the round-robin pointer to 0.
REQ-036 Reset asserted during LAUNCH SHALL abort the launch with no acc_ack_o pulse.

Configuration
REQ-037 With macro CGRA_SCHED_RR_EN defined, SHALL use round-robin priority: search starts at the slot after the last granted slot, and the pointer updates in ACK.
REQ-038 With CGRA_SCHED_RR_EN undefined, SHALL use fixed priority with the lowest slot index winning, and SHALL contain no pointer register.

Structure
REQ-039 SHALL place the state enum, N_SLOTS, N_COL and the slot-index width in the shared cgra_pkg.
REQ-040 SHALL implement the window search as combinational sub-module cgra_col_alloc, taking the busy mask and ncol and returning the mask and a fit flag.

Verification
REQ-041 Slot0 ID=3, ncol=1, all columns free, ready=1 -> valid at cycle 2, mask 0011, one acc_ack pulse, clear=0.
REQ-042 col_status=0101, slot0 ncol=1 -> no fit, stays in ARB; col_status changes to 0001 -> mask 0110.
REQ-043 Slot0 ncol=3 with col0 busy, slot1 ncol=0 -> slot1 granted mask 0010; slot0 still pending.
REQ-044 With RR_EN, both slots requesting continuously with ncol=0 -> grants alternate 0,1,0,1; without RR_EN -> always slot 0.
REQ-045 ready held low for 5 cycles -> ID and mask stable, no ack; ack occurs 1 cycle after ready.
REQ-046 rst_ni pulsed low in LAUNCH -> all outputs 0 immediately, state IDLE, no ack.
